// File: rtl/jtkicker_sdram_resp_if.sv
// Bus bundle between the kicker-family SDRAM requesters (download path and
// slot arbiter) and the on-chip responder that stands in for the SDRAM.
interface jtkicker_sdram_resp_if;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;
  logic        busy;

  modport master (
    output downloading, prog_addr, prog_data, prog_mask, prog_we,
           sdram_req, sdram_addr,
    input  prog_ack, sdram_ack, data_dst, data_rdy, data_read, busy
  );

  modport slave (
    input  downloading, prog_addr, prog_data, prog_mask, prog_we,
           sdram_req, sdram_addr,
    output prog_ack, sdram_ack, data_dst, data_rdy, data_read, busy
  );
endinterface

// File: rtl/jtkicker_sdram_resp.sv
// On-chip 16-bit memory answering SDRAM-style byte downloads and burst reads,
// with fixed ack-to-data latency and a fixed burst length.
module jtkicker_sdram_resp #(
  parameter int AW      = 16,
  parameter int LATENCY = 4,
  parameter int BURST   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  jtkicker_sdram_resp_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_BURST = 2'd3;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [1:0]    LAST_IDX = 2'(BURST - 1);

  logic [15:0]   mem [0:(1<<AW)-1];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          prog_ack_q, prog_ack_d;
  logic          sdram_ack_q, sdram_ack_d;
  logic          dst_q, dst_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   data_read_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [1:0]    wr_mask_q;
  logic          wr_cap;
  logic          wr_commit;
  logic          rd_en;
  logic          unused_in;

  // Upper address bits alias by design; downloading is informational only.
  assign unused_in = ^{bus.downloading, bus.sdram_addr, bus.prog_addr};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    prog_ack_d  = 1'b0;
    sdram_ack_d = 1'b0;
    dst_d       = 1'b0;
    rdy_d       = 1'b0;
    wr_cap      = 1'b0;
    wr_commit   = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.prog_we) begin
          state_d    = ST_WRITE;
          prog_ack_d = 1'b1;
          wr_cap     = 1'b1;
        end else if (bus.sdram_req) begin
          state_d     = ST_WAIT;
          sdram_ack_d = 1'b1;
          cnt_d       = CNT_INIT;
          addr_d      = bus.sdram_addr[AW-1:0];
        end
      end
      ST_WRITE: begin
        wr_commit = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_WAIT: begin
        // Word 0 is fetched here so it is registered onto the bus in the
        // first BURST cycle.
        if (cnt_q == '0) begin
          state_d = ST_BURST;
          idx_d   = 2'd0;
          rd_en   = 1'b1;
          dst_d   = 1'b1;
          rdy_d   = (LAST_IDX == 2'd0);
          addr_d  = addr_q + AW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d  = idx_q + 2'd1;
          rd_en  = 1'b1;
          dst_d  = 1'b1;
          rdy_d  = ((idx_q + 2'd1) == LAST_IDX);
          addr_d = addr_q + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      prog_ack_q  <= 1'b0;
      sdram_ack_q <= 1'b0;
      dst_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      prog_ack_q  <= prog_ack_d;
      sdram_ack_q <= sdram_ack_d;
      dst_q       <= dst_d;
      rdy_q       <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (wr_cap) begin
      wr_addr_q <= bus.prog_addr[AW-1:0];
      wr_data_q <= bus.prog_data;
      wr_mask_q <= bus.prog_mask;
    end
  end

  // A reset landing on the commit cycle drops the pending write.
  always_ff @(posedge clk) begin
    if (wr_commit && !rst) begin
      if (!wr_mask_q[0]) mem[wr_addr_q][7:0]  <= wr_data_q;
      if (!wr_mask_q[1]) mem[wr_addr_q][15:8] <= wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_read_q <= '0;
    end else if (rd_en) begin
      data_read_q <= mem[addr_q];
    end
  end

  assign bus.prog_ack  = prog_ack_q;
  assign bus.sdram_ack = sdram_ack_q;
  assign bus.data_dst  = dst_q;
  assign bus.data_rdy  = rdy_q;
  assign bus.data_read = data_read_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
